// File: rtl/dispatch_router_if.sv
// Dispatch router types and the rename/CDB/RS-facing bundle.
// Package comes first so the interface and the router can share uop_t.
package dispatch_router_pkg;
  localparam int ID_WIDTH  = 2;
  localparam int N_RS      = 3;
  localparam int CDB_WIDTH = 2;
  localparam int PRF_IDX   = 6;

  // rs_type is wide enough to encode illegal targets (>= N_RS)
  typedef struct packed {
    logic [1:0]         rs_type;
    logic [PRF_IDX-1:0] rs1_phy;
    logic               rs1_valid;
    logic [PRF_IDX-1:0] rs2_phy;
    logic               rs2_valid;
  } uop_t;
endpackage

interface dispatch_router_if;
  import dispatch_router_pkg::*;

  logic                                flush;
  logic [ID_WIDTH-1:0]                 ren_valid;
  uop_t [ID_WIDTH-1:0]                 ren_uop;
  logic                                ren_ready;
  logic [CDB_WIDTH-1:0]                cdb_valid;
  logic [CDB_WIDTH-1:0][PRF_IDX-1:0]   cdb_rd_phy;
  logic [N_RS-1:0][ID_WIDTH-1:0]       rs_valid;
  uop_t [ID_WIDTH-1:0]                 rs_uop;
  logic [N_RS-1:0]                     rs_ready;

  modport master (
    output flush, ren_valid, ren_uop, cdb_valid, cdb_rd_phy, rs_ready,
    input  ren_ready, rs_valid, rs_uop
  );

  modport slave (
    input  flush, ren_valid, ren_uop, cdb_valid, cdb_rd_phy, rs_ready,
    output ren_ready, rs_valid, rs_uop
  );
endinterface

// File: rtl/dispatch_router.sv
// Dispatch stage: latches one rename group and pushes each lane to its RS, snooping the CDB while held.
// Optional DISPATCH_PERF_CNT_EN adds a saturating stall_cnt output.
module dispatch_router
  import dispatch_router_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  dispatch_router_if.slave  bus
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  uop_t [ID_WIDTH-1:0] g_reg;
  uop_t [ID_WIDTH-1:0] woken;
  logic [ID_WIDTH-1:0] pend_reg;
  logic [ID_WIDTH-1:0] fire;
  logic [ID_WIDTH-1:0] drop;
  logic [ID_WIDTH-1:0] done;
  logic                accept;

  // Merge CDB hits and the hardwired-valid p0 into a uop's source valid bits.
  function automatic uop_t wake(input uop_t u,
                                input logic [CDB_WIDTH-1:0] cv,
                                input logic [CDB_WIDTH-1:0][PRF_IDX-1:0] cp);
    uop_t w;
    w = u;
    for (int k = 0; k < CDB_WIDTH; k++) begin
      if (cv[k] && cp[k] == u.rs1_phy) w.rs1_valid = 1'b1;
      if (cv[k] && cp[k] == u.rs2_phy) w.rs2_valid = 1'b1;
    end
    if (u.rs1_phy == '0) w.rs1_valid = 1'b1;
    if (u.rs2_phy == '0) w.rs2_valid = 1'b1;
    return w;
  endfunction

  genvar gi, gt;
  generate
    for (gi = 0; gi < ID_WIDTH; gi++) begin : g_lane
      logic [N_RS-1:0] sel;

      for (gt = 0; gt < N_RS; gt++) begin : g_rs
        assign sel[gt]             = g_reg[gi].rs_type == 2'(gt);
        assign bus.rs_valid[gt][gi] = pend_reg[gi] && sel[gt];
      end

      // An illegal rs_type matches no RS, so the lane is dropped instead of pushed.
      assign fire[gi]  = pend_reg[gi] && |(sel & bus.rs_ready);
      assign drop[gi]  = pend_reg[gi] && !(|sel);
      assign woken[gi] = wake(g_reg[gi], bus.cdb_valid, bus.cdb_rd_phy);
      assign bus.rs_uop[gi] = woken[gi];

      // Held lanes keep absorbing wakeups so no broadcast is missed before the push.
      always_ff @(posedge clk) begin
        if (accept) begin
          g_reg[gi] <= wake(bus.ren_uop[gi], bus.cdb_valid, bus.cdb_rd_phy);
        end else begin
          g_reg[gi] <= woken[gi];
        end
      end
    end
  endgenerate

  assign done          = fire | drop;
  assign bus.ren_ready = !bus.flush && ((pend_reg & ~done) == '0);
  assign accept        = bus.ren_ready && (|bus.ren_valid);

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      pend_reg <= '0;
    end else if (accept) begin
      pend_reg <= bus.ren_valid;
    end else begin
      pend_reg <= pend_reg & ~done;
    end
  end

  a_rs_type_legal: assert property (@(posedge clk) disable iff (rst) drop == '0);

`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (((pend_reg & ~fire) != '0) && !bus.flush && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_dispatch_router.sv
// Directed bench for dispatch_router: routing, partial dispatch, CDB wakeup, flush, reset and throughput.
// Define DISPATCH_PERF_CNT_EN to also exercise stall_cnt.
module tb_dispatch_router;
  import dispatch_router_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dispatch_router_if bus();
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  dispatch_router dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DISPATCH_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("check %s: got=%0h ok", tag, got);
    end
  endtask

  function automatic uop_t mk(input logic [1:0] ty, input logic [5:0] p1, input logic v1,
                              input logic [5:0] p2, input logic v2);
    uop_t u;
    u.rs_type   = ty;
    u.rs1_phy   = p1;
    u.rs1_valid = v1;
    u.rs2_phy   = p2;
    u.rs2_valid = v2;
    return u;
  endfunction

  task automatic idle();
    bus.flush      = 1'b0;
    bus.ren_valid  = '0;
    bus.ren_uop[0] = mk(2'd0, 6'd1, 1'b1, 6'd1, 1'b1);
    bus.ren_uop[1] = mk(2'd0, 6'd1, 1'b1, 6'd1, 1'b1);
    bus.cdb_valid  = '0;
    bus.cdb_rd_phy = '0;
    bus.rs_ready   = 3'b111;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] exp_rv;
    logic [5:0] prev_rv;
    int         t0, t1;

    rst = 1'b1;
    idle();
    repeat (2) cycle();
    rst = 1'b0;
    #2;
    check("rst_rs_valid", bus.rs_valid, 0);
    check("rst_ren_ready", bus.ren_ready, 1);

    // lane0 int, lane1 mem, all ready
    bus.ren_valid  = 2'b11;
    bus.ren_uop[0] = mk(2'd0, 6'd5, 1'b1, 6'd6, 1'b1);
    bus.ren_uop[1] = mk(2'd2, 6'd7, 1'b0, 6'd8, 1'b0);
    cycle();
    bus.ren_valid = '0;
    #2;
    check("basic_rs_valid", bus.rs_valid, 6'b100001);
    check("basic_ren_ready", bus.ren_ready, 1);
    check("basic_l1_rs1v", bus.rs_uop[1].rs1_valid, 0);
    check("basic_l0_rs1p", bus.rs_uop[0].rs1_phy, 5);
    cycle();
    #2;
    check("basic_drained", bus.rs_valid, 0);

    // both lanes to intm fire together
    bus.ren_valid  = 2'b11;
    bus.ren_uop[0] = mk(2'd1, 6'd11, 1'b1, 6'd12, 1'b1);
    bus.ren_uop[1] = mk(2'd1, 6'd13, 1'b1, 6'd14, 1'b1);
    cycle();
    bus.ren_valid = '0;
    #2;
    check("same_rs_valid", bus.rs_valid, 6'b001100);
    cycle();
    #2;
    check("same_rs_drained", bus.rs_valid, 0);

    // lane0 intm stalled 3 cycles, lane1 int goes at once
    bus.rs_ready   = 3'b101;
    bus.ren_valid  = 2'b11;
    bus.ren_uop[0] = mk(2'd1, 6'd10, 1'b1, 6'd3, 1'b1);
    bus.ren_uop[1] = mk(2'd0, 6'd15, 1'b1, 6'd3, 1'b1);
    cycle();
    bus.ren_valid = '0;
    #2;
    check("part_c1_rs_valid", bus.rs_valid, 6'b000110);
    check("part_c1_ren_ready", bus.ren_ready, 0);
    cycle();
    // offered group must not be taken while stalled
    bus.ren_valid  = 2'b01;
    bus.ren_uop[0] = mk(2'd2, 6'd33, 1'b1, 6'd34, 1'b1);
    #2;
    check("part_c2_rs_valid", bus.rs_valid, 6'b000100);
    check("part_c2_ren_ready", bus.ren_ready, 0);
    cycle();
    #2;
    check("part_c3_rs_valid", bus.rs_valid, 6'b000100);
    check("part_c3_ren_ready", bus.ren_ready, 0);
    bus.rs_ready = 3'b111;
    #1;
    check("part_c3_ready_up", bus.ren_ready, 1);
    cycle();
    bus.ren_valid = '0;
    #2;
    check("part_c4_next_grp", bus.rs_valid, 6'b010000);
    check("part_c4_rs1p", bus.rs_uop[0].rs1_phy, 33);
    cycle();

    // wakeup of a held mem uop
    bus.rs_ready   = 3'b011;
    bus.ren_valid  = 2'b01;
    bus.ren_uop[0] = mk(2'd2, 6'd17, 1'b0, 6'd20, 1'b0);
    cycle();
    bus.ren_valid = '0;
    #2;
    check("wake_before", bus.rs_uop[0].rs1_valid, 0);
    bus.cdb_valid     = 2'b10;
    bus.cdb_rd_phy[1] = 6'd17;
    bus.cdb_rd_phy[0] = 6'd20;
    #2;
    check("wake_same_cycle", bus.rs_uop[0].rs1_valid, 1);
    check("wake_gated_port", bus.rs_uop[0].rs2_valid, 0);
    cycle();
    bus.cdb_valid = '0;
    #2;
    check("wake_held1", bus.rs_uop[0].rs1_valid, 1);
    check("wake_still_pend", bus.rs_valid, 6'b010000);
    cycle();
    #2;
    check("wake_held2", bus.rs_uop[0].rs1_valid, 1);
    bus.rs_ready = 3'b111;
    cycle();
    #2;
    check("wake_drained", bus.rs_valid, 0);

    // non-contiguous lane, p0 always valid, bypass at accept
    bus.ren_valid     = 2'b10;
    bus.ren_uop[1]    = mk(2'd0, 6'd0, 1'b0, 6'd9, 1'b0);
    bus.cdb_valid     = 2'b01;
    bus.cdb_rd_phy[0] = 6'd9;
    cycle();
    bus.ren_valid = '0;
    bus.cdb_valid = '0;
    #2;
    check("nc_rs_valid", bus.rs_valid, 6'b000010);
    check("p0_rs1v", bus.rs_uop[1].rs1_valid, 1);
    check("bypass_rs2v", bus.rs_uop[1].rs2_valid, 1);
    cycle();

    // flush a pending uop together with an offered group
    bus.rs_ready   = 3'b011;
    bus.ren_valid  = 2'b01;
    bus.ren_uop[0] = mk(2'd2, 6'd21, 1'b1, 6'd22, 1'b1);
    cycle();
    #2;
    check("flush_pre_pend", bus.rs_valid, 6'b010000);
    bus.flush      = 1'b1;
    bus.ren_valid  = 2'b11;
    bus.ren_uop[0] = mk(2'd0, 6'd23, 1'b1, 6'd24, 1'b1);
    bus.ren_uop[1] = mk(2'd1, 6'd25, 1'b1, 6'd26, 1'b1);
    #1;
    check("flush_ren_ready", bus.ren_ready, 0);
    cycle();
    bus.flush     = 1'b0;
    bus.ren_valid = 2'b01;
    bus.rs_ready  = 3'b111;
    #2;
    check("flush_no_valid", bus.rs_valid, 0);
    check("flush_ready_after", bus.ren_ready, 1);
    cycle();
    bus.ren_valid = '0;
    #2;
    check("flush_new_grp", bus.rs_valid, 6'b000001);
    cycle();

    // 8 back-to-back groups
    prev_rv = '0;
    for (int g = 0; g < 8; g++) begin
      t0 = g % 3;
      t1 = (g + 1) % 3;
      bus.ren_valid  = 2'b11;
      bus.ren_uop[0] = mk(2'(t0), 6'(2 * g + 1), 1'b1, 6'd40, 1'b1);
      bus.ren_uop[1] = mk(2'(t1), 6'(2 * g + 2), 1'b1, 6'd41, 1'b1);
      #2;
      check($sformatf("b2b%0d_ren_ready", g), bus.ren_ready, 1);
      if (g > 0) begin
        check($sformatf("b2b%0d_rs_valid", g - 1), bus.rs_valid, prev_rv);
        check($sformatf("b2b%0d_l0p", g - 1), bus.rs_uop[0].rs1_phy, 2 * (g - 1) + 1);
        check($sformatf("b2b%0d_l1p", g - 1), bus.rs_uop[1].rs1_phy, 2 * (g - 1) + 2);
      end
      exp_rv = '0;
      exp_rv[t0 * 2]     = 1'b1;
      exp_rv[t1 * 2 + 1] = 1'b1;
      prev_rv = exp_rv;
      cycle();
    end
    bus.ren_valid = '0;
    #2;
    check("b2b7_rs_valid", bus.rs_valid, prev_rv);
    check("b2b7_l0p", bus.rs_uop[0].rs1_phy, 15);
    cycle();

    // reset while a uop is held
    bus.rs_ready   = 3'b011;
    bus.ren_valid  = 2'b01;
    bus.ren_uop[0] = mk(2'd2, 6'd30, 1'b1, 6'd31, 1'b1);
    cycle();
    bus.ren_valid = '0;
    #2;
    check("rstmid_pend", bus.rs_valid, 6'b010000);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #2;
    check("rstmid_no_valid", bus.rs_valid, 0);
    check("rstmid_ren_ready", bus.ren_ready, 1);

`ifdef DISPATCH_PERF_CNT_EN
    check("perf_rst", stall_cnt, 0);
    bus.ren_valid  = 2'b01;
    bus.ren_uop[0] = mk(2'd2, 6'd35, 1'b1, 6'd36, 1'b1);
    cycle();
    bus.ren_valid = '0;
    repeat (5) cycle();
    #2;
    check("perf_cnt5", stall_cnt, 5);
    bus.rs_ready = 3'b111;
    cycle();
    #2;
    check("perf_hold", stall_cnt, 5);
    check("perf_drained", bus.rs_valid, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
